serial_add_sequencer: RTL and testbench

//  Bit-serial adder controller. Reuses one 1-bit half-adder pair (sum=x^y, carry=x&y), wired as a full adder.

---
 rtl/serial_add_sequencer.sv | 113 +++++++++++
 tb/tb_serial_add_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller: walks one full-adder cell (two half adders plus OR)
// LSB-first across two WIDTH-bit operands, with valid/ready on both operand and result sides.
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CNT_W-1:0] cnt;
  logic             carry;

  logic [1:0] ha_lo;
  logic [1:0] ha_hi;
  logic       bit_s;
  logic       bit_c;

  // Shared 1-bit cell; returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Full adder built from the two half adders; carries from both halves are ORed.
  always_comb begin
    ha_lo = half_add(a_sr[0], b_sr[0]);
    ha_hi = half_add(ha_lo[0], carry);
    bit_s = ha_hi[0];
    bit_c = ha_lo[1] | ha_hi[1];
  end

  // Operand shift registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid && in_ready) begin
      a_sr <= a;
      b_sr <= b;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            carry    <= 1'b0;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          // Result assembles by shifting each new bit in at the MSB end.
          sum   <= {bit_s, sum[WIDTH-1:1]};
          carry <= bit_c;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            carry_out <= bit_c;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Scoreboard bench for serial_add_sequencer: expected {carry,sum} queued on accept,
// popped and compared when the result handshake is offered.
module tb_serial_add_sequencer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             busy;

  int tests = 0;
  int fails = 0;
  logic [WIDTH:0] sb[$];

  serial_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair until accepted; queue the reference result on acceptance.
  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, output bit ok);
    in_valid = 1'b1;
    a = x;
    b = y;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (ok) sb.push_back({1'b0, x} + {1'b0, y});
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    tick(); tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if ({busy, carry_out, sum} !== '0) begin fails++; $display("FAIL reset_busy_carry_sum got %b/%b/%h want 0/0/00", busy, carry_out, sum); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok; int n; logic [WIDTH:0] exp;
    out_ready = 1'b1;
    send(8'h0F, 8'h01, ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_accept got 0 want 1"); end
    tests++; if ({busy, in_ready} !== 2'b10) begin fails++; $display("FAIL basic_busy_ready got %b want 10", {busy, in_ready}); end
    wait_valid(n);
    tests++; if (n !== WIDTH) begin fails++; $display("FAIL basic_latency got %0d want %0d", n, WIDTH); end
    if (sb.size() == 0) begin tests++; fails++; $display("FAIL basic_scoreboard got empty want entry"); end
    else begin
      exp = sb.pop_front();
      tests++; if ({carry_out, sum} !== exp) begin fails++; $display("FAIL basic_result got %h want %h", {carry_out, sum}, exp); end
    end
    tick();
    tests++; if ({in_ready, out_valid, busy} !== 3'b100) begin fails++; $display("FAIL basic_return_idle got %b want 100", {in_ready, out_valid, busy}); end
  endtask

  task automatic test_carry();
    logic [WIDTH-1:0] xs[2] = '{8'hFF, 8'hFF};
    logic [WIDTH-1:0] ys[2] = '{8'h01, 8'hFF};
    logic [WIDTH:0]   want[2] = '{9'h100, 9'h1FE};
    bit ok; int n; logic [WIDTH:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(xs[i], ys[i], ok);
      wait_valid(n);
      tests++; if (n !== WIDTH) begin fails++; $display("FAIL carry_latency_%0d got %0d want %0d", i, n, WIDTH); end
      exp = (sb.size() != 0) ? sb.pop_front() : 'x;
      tests++; if ({carry_out, sum} !== exp || exp !== want[i]) begin fails++; $display("FAIL carry_result_%0d got %h want %h", i, {carry_out, sum}, want[i]); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit ok; int n; logic [WIDTH:0] exp;
    out_ready = 1'b0;
    send(8'hC3, 8'h7E, ok);
    wait_valid(n);
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({out_valid, in_ready, carry_out, sum} !== {2'b10, exp}) begin
        fails++;
        $display("FAIL hold_cycle_%0d got v=%b r=%b res=%h want v=1 r=0 res=%h", i, out_valid, in_ready, {carry_out, sum}, exp);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    tests++; if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL hold_release got %b want 01", {out_valid, in_ready}); end
    tests++; if ({carry_out, sum} !== exp) begin fails++; $display("FAIL hold_keep_result got %h want %h", {carry_out, sum}, exp); end
  endtask

  task automatic test_ignore_in_run();
    bit ok; int n; logic [WIDTH:0] exp;
    out_ready = 1'b1;
    send(8'h12, 8'h34, ok);
    tick(); tick();
    in_valid = 1'b1; a = 8'hAA; b = 8'hAA;
    tick(); tick(); tick();
    in_valid = 1'b0;
    wait_valid(n);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ignore_valid got %b want 1", out_valid); end
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    tests++; if ({carry_out, sum} !== exp || exp !== 9'h046) begin fails++; $display("FAIL ignore_result got %h want 046", {carry_out, sum}); end
    tick(); tick(); tick();
    tests++; if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL ignore_no_extra got %b want 01", {out_valid, in_ready}); end
  endtask

  task automatic test_reset_mid_run();
    bit ok; int n; logic [WIDTH:0] exp;
    out_ready = 1'b1;
    send(8'hF0, 8'h0F, ok);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    if (sb.size() != 0) void'(sb.pop_front());
    tests++; if ({in_ready, out_valid, busy, carry_out, sum} !== {4'b1000, 8'h00}) begin fails++; $display("FAIL midreset_state got r=%b v=%b busy=%b res=%h want r=1 v=0 busy=0 res=000", in_ready, out_valid, busy, {carry_out, sum}); end
    rst_n = 1'b1;
    tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_no_partial got %b want 0", out_valid); end
    send(8'h21, 8'h43, ok);
    wait_valid(n);
    tests++; if (n !== WIDTH) begin fails++; $display("FAIL midreset_latency got %0d want %0d", n, WIDTH); end
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    tests++; if ({carry_out, sum} !== exp || exp !== 9'h064) begin fails++; $display("FAIL midreset_result got %h want 064", {carry_out, sum}); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] xs[3] = '{8'd1, 8'd100, 8'd200};
    logic [WIDTH-1:0] ys[3] = '{8'd2, 8'd27, 8'd100};
    logic [WIDTH:0]   want[3] = '{9'd3, 9'd127, 9'd300};
    bit ok; int n; logic [WIDTH:0] exp;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = xs[0]; b = ys[0];
    for (int i = 0; i < 3; i++) begin
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
        ok = in_ready;
        tick();
      end
      tests++; if (!ok) begin fails++; $display("FAIL b2b_accept_%0d got 0 want 1", i); end
      sb.push_back({1'b0, xs[i]} + {1'b0, ys[i]});
      wait_valid(n);
      tests++; if (n !== WIDTH) begin fails++; $display("FAIL b2b_latency_%0d got %0d want %0d", i, n, WIDTH); end
      exp = (sb.size() != 0) ? sb.pop_front() : 'x;
      tests++; if ({carry_out, sum} !== exp || exp !== want[i]) begin fails++; $display("FAIL b2b_result_%0d got %h want %h", i, {carry_out, sum}, want[i]); end
      if (i < 2) begin a = xs[i+1]; b = ys[i+1]; end
      else in_valid = 1'b0;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_no_bypass_%0d got %b want 0", i, in_ready); end
      tick();
      tests++; if ({in_ready, out_valid} !== 2'b10) begin fails++; $display("FAIL b2b_ready_rise_%0d got %b want 10", i, {in_ready, out_valid}); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_ignore_in_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
